instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage of the piRISC pipeline, upstream of instruction_memory. Owns the PC; drives the
//  memory enable and address; absorbs the memory's 1-cycle synchronous read latency. Presents
//  a registered {pc, instr, valid} IF/ID bundle to decode. Supports a decode stall and a
//  branch/jump redirect with flush.
// PARAMETERS
//  DWIDTH    32            PC, address and instruction width
//  RESET_PC  32'h00000000  first fetch address after reset
//  PC_STEP   4             byte increment per sequential fetch
// PORTS
//  clk          in   1       clock; all state changes on posedge
//  reset        in   1       synchronous, active-high
//  stall        in   1       decode cannot accept; hold the IF/ID bundle
//  redirect     in   1       taken branch/jump; flush and refetch from redirect_pc
//  redirect_pc  in   DWIDTH  redirect target; bits [1:0] are ignored (forced to 0)
//  imem_en      out  1       to instruction_memory.enable (combinational)
//  imem_addr    out  DWIDTH  to instruction_memory.addressIn (combinational, = pc)
//  imem_data    in   DWIDTH  from instruction_memory.instructionOut
//  if_pc        out  DWIDTH  PC of if_instr (registered)
//  if_instr     out  DWIDTH  fetched instruction (registered)
//  if_valid     out  1       if_pc/if_instr are valid (registered)
// BEHAVIOUR
//  - Reset: pc<=RESET_PC; req_valid, skid_valid and if_valid <= 0; if_pc<=0; if_instr<=NOP (32'h00000013).
//    imem_en is forced to 0 while reset is high.
//  - imem_en = ~reset & ~stall & ~redirect. imem_addr = pc at all times.
//  - Issue: at an edge with imem_en=1, memory samples pc; pc<=pc+PC_STEP (mod 2^DWIDTH; wraps
//    0xFFFFFFFC->0); req_valid<=1 and req_pc<=pc. Otherwise req_valid<=0.
//  - Latency: an instruction issued at edge E appears on imem_data after E and is loaded into
//    if_* at E+1, so in streaming there is 1 fetch per cycle and if_valid stays high.
//  - Output update (~stall, ~redirect): if skid_valid, load skid; else if req_valid, load
//    {req_pc, imem_data}, valid=1; else valid=0.
//  - Stall (stall=1, redirect=0): if_* hold; no issue; pc holds. If req_valid, the returning
//    word is captured into the skid {skid_pc, skid_instr}, skid_valid<=1. imem_data is not
//    relied on to hold while disabled.
//  - Stall release: the skid drains to if_* at the same edge a new fetch issues, with no bubble
//    and no duplicated or lost instruction. skid_valid<=0.
//  - Redirect (priority over stall and over reset-free state): at edge sampling redirect=1:
//    pc<={redirect_pc[DWIDTH-1:2],2'b00}; req_valid<=0; skid_valid<=0; if_valid<=0 (even if
//    stall=1); no issue. The target issues at the next edge, and if_valid=1 with if_pc=target
//    after the edge after that (2-cycle redirect bubble).
//  - Back-to-back redirects: the last one wins; each flushes again.
//  - Reset mid-stall/mid-redirect: reset overrides everything; the state is as in Reset.
// STRUCTURE
//  - piriscv_pkg: NOP_INSTR (32'h00000013), RESET_PC default, DWIDTH default.
//  - Sub-module fetch_skid_buffer: a 1-entry {pc,instr} holding register with load/drain/clear
//    and a valid bit. The PC, issue and IF/ID register logic lives in the top module.
// TESTING (bench uses real instruction_memory, mem[i]=32'hA000_0000+i)
//  1. reset 3 cycles -> imem_en=0, if_valid=0, if_instr=0x13. Release -> after 2nd edge:
//     if_pc=0, if_instr=A0000000, valid=1.
//  2. Stream 8 cycles -> if_pc 0,4,...,28 on consecutive cycles; if_instr=A0000000+pc/4; no bubble.
//  3. Stall 3 cycles while streaming at if_pc=8 -> if_* hold at 8. Release -> 12,16,20
//     consecutively; no skip and no repeat.
//  4. Redirect redirect_pc=0x40 when if_pc=0x10 -> if_valid=0 for 2 cycles, then if_pc=0x40,
//     instr=A0000010, then 0x44.
//  5. Redirect asserted with stall=1, redirect_pc=0x23 -> if_valid=0 next cycle, the skid is
//     cleared, and the fetch resumes at 0x20 once stall drops.
//  6. Redirect to 0xFFFFFFFC -> next if_pc=0xFFFFFFFC, then 0x00000000 (wrap).

Source files
------------

// File: rtl/piriscv_pkg.sv
// Shared constants for the piRISC pipeline front end.
package piriscv_pkg;

  localparam int          DWIDTH_DEFAULT   = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_STEP_DEFAULT  = 4;

  // addi x0, x0, 0 -- the canonical RISC-V NOP, parked in IF/ID when nothing is valid.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage : piriscv_pkg

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register used to catch the word that returns
// from instruction memory while decode is stalled.
module fetch_skid_buffer
  import piriscv_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              drain,
  input  logic [DWIDTH-1:0] load_pc,
  input  logic [DWIDTH-1:0] load_instr,
  output logic              valid,
  output logic [DWIDTH-1:0] pc,
  output logic [DWIDTH-1:0] instr
);

  // Priority: reset, then clear (flush), then load, then drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= DWIDTH'(NOP_INSTR);
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule : fetch_skid_buffer

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction memory (1-cycle synchronous
// read), and presents a registered {pc, instr, valid} IF/ID bundle to decode.
//
// Handshake with decode: if_valid is the valid, ~stall is the ready. The bundle
// is consumed at a posedge where if_valid=1 and stall=0; while stall=1 the bundle
// is held stable. redirect squashes the bundle and everything in flight.
module instruction_fetch
  import piriscv_pkg::*;
#(
  parameter int                    DWIDTH   = DWIDTH_DEFAULT,
  parameter logic [DWIDTH_DEFAULT-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                    PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [DWIDTH-1:0] redirect_pc,
  output logic              imem_en,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic [DWIDTH-1:0] imem_data,
  output logic [DWIDTH-1:0] if_pc,
  output logic [DWIDTH-1:0] if_instr,
  output logic              if_valid
);

  localparam logic [DWIDTH-1:0] NOP  = DWIDTH'(NOP_INSTR);
  localparam logic [DWIDTH-1:0] STEP = DWIDTH'(PC_STEP);

  logic [DWIDTH-1:0] pc;
  logic              req_valid;   // a word requested at the previous edge is on imem_data
  logic [DWIDTH-1:0] req_pc;
  logic [DWIDTH-1:0] redirect_target;

  logic              skid_valid;
  logic [DWIDTH-1:0] skid_pc;
  logic [DWIDTH-1:0] skid_instr;
  logic              skid_load;
  logic              skid_drain;

  // Targets are word aligned; the low two bits of redirect_pc carry no meaning.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_target      = {redirect_pc[DWIDTH-1:2], 2'b00};

  // Memory is only enabled when the stage can actually advance.
  assign imem_en   = ~reset & ~stall & ~redirect;
  assign imem_addr = pc;

  // Catch the in-flight word when decode stalls; hand it over when the stall drops.
  assign skid_load  = ~reset & ~redirect & stall & req_valid;
  assign skid_drain = ~reset & ~redirect & ~stall & skid_valid;

  fetch_skid_buffer #(
    .DWIDTH(DWIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .load      (skid_load),
    .drain     (skid_drain),
    .load_pc   (req_pc),
    .load_instr(imem_data),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .instr     (skid_instr)
  );

  // PC and outstanding-request tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC[DWIDTH-1:0];
      req_valid <= 1'b0;
      req_pc    <= '0;
    end else if (redirect) begin
      pc        <= redirect_target;
      req_valid <= 1'b0;
    end else if (imem_en) begin
      pc        <= pc + STEP;
      req_valid <= 1'b1;
      req_pc    <= pc;
    end else begin
      req_valid <= 1'b0;
    end
  end

  // IF/ID register: skid has priority over the fresh memory word so order is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= NOP;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (!stall) begin
      if (skid_valid) begin
        if_valid <= 1'b1;
        if_pc    <= skid_pc;
        if_instr <= skid_instr;
      end else if (req_valid) begin
        if_valid <= 1'b1;
        if_pc    <= req_pc;
        if_instr <= imem_data;
      end else begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule : instruction_fetch
